mem_stage_lsu: RTL

- Load/store unit that consumes the MEM-stage fields of the control word: mem_read, mem_write, store_formatter_op and load_formatter_op.
- Turns them into a data-memory request with handshake, then formats the returned data.
- Drives the MEM_ready signal that gates the pipeline.
- Sits between the EX/MEM pipeline register and the data cache port.

---
 rtl/mem_stage_lsu_if.sv | 35 +++
 rtl/mem_stage_lsu.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu_if.sv
// Data-memory port of the MEM-stage load/store unit.
//
// Handshake: the LSU (master) raises exactly one of dmem_read/dmem_write and
// holds it, together with dmem_address, dmem_wdata and dmem_byte_enable,
// constant until the memory (slave) answers with a one-cycle dmem_resp pulse.
// dmem_rdata is only meaningful in the cycle dmem_resp is high. The LSU
// drops the strobe on the edge that samples dmem_resp.
//
// Signals:
//   dmem_read        master->slave  read strobe
//   dmem_write       master->slave  write strobe
//   dmem_address     master->slave  word-aligned byte address
//   dmem_wdata       master->slave  lane-aligned store data
//   dmem_byte_enable master->slave  write byte mask (0 for reads)
//   dmem_resp        slave->master  completion pulse
//   dmem_rdata       slave->master  read word, valid with dmem_resp
interface mem_stage_lsu_if;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_byte_enable;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    input  dmem_resp, dmem_rdata
  );

  modport slave (
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    output dmem_resp, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit. Converts the mem_read/mem_write/store_op/load_op
// fields of the control word into a data-memory request, waits for the
// response, formats the returned data and drives MEM_ready (ready).
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid            MEM-stage instruction present
//   mem_read, mem_write  access direction (write wins if both set)
//   store_op, load_op    funct3 of the store / load
//   addr, store_data     byte address and rs2 value
//   dmem                 data-memory port (master side)
//   ready                stage may advance this cycle
//   load_data            formatted load result, valid with ready in DONE
//   misaligned           misaligned access, valid with ready
//   bus_error            response timeout, valid with ready
//   dbg_state            current FSM state (0 IDLE, 1 ACCESS, 2 DONE)
//
// Request/ready semantics: an access is taken in IDLE when req_valid and a
// direction bit are high; ready is then low until the single DONE cycle.
// Inputs are latched on acceptance and ignored while ready is low.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [2:0]    store_op,
  input  logic [2:0]    load_op,
  input  logic [31:0]   addr,
  input  logic [31:0]   store_data,
  mem_stage_lsu_if.master dmem,
  output logic          ready,
  output logic [31:0]   load_data,
  output logic          misaligned,
  output logic          bus_error,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t      state;
  logic [1:0]  addr_off_q;
  logic [2:0]  load_op_q;
  logic [31:0] tmo_cnt;

  logic        access_req;
  logic        mis_req;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;

  assign access_req = req_valid && (mem_read || mem_write);
  assign ready      = (state == S_DONE) || ((state == S_IDLE) && !access_req);
  assign dbg_state  = state;

  // Alignment check; undefined codes follow the word rules.
  always_comb begin
    mis_req = 1'b0;
    if (mem_write) begin
      case (store_op)
        F3_B:    mis_req = 1'b0;
        F3_H:    mis_req = addr[0];
        default: mis_req = |addr[1:0];
      endcase
    end else begin
      case (load_op)
        F3_B, F3_BU: mis_req = 1'b0;
        F3_H, F3_HU: mis_req = addr[0];
        default:     mis_req = |addr[1:0];
      endcase
    end
  end

  // Store lane replication and byte mask; undefined codes store a word.
  always_comb begin
    st_wdata = store_data;
    st_be    = 4'b1111;
    case (store_op)
      F3_B: begin
        st_wdata = {4{store_data[7:0]}};
        st_be    = 4'b0001 << addr[1:0];
      end
      F3_H: begin
        st_wdata = {2{store_data[15:0]}};
        st_be    = 4'b0011 << {addr[1], 1'b0};
      end
      default: ;
    endcase
  end

  function automatic logic [31:0] format_load(input logic [2:0]  op,
                                              input logic [1:0]  off,
                                              input logic [31:0] rdata);
    logic [31:0] shifted;
    shifted = rdata >> {off, 3'b000};
    case (op)
      F3_B:    format_load = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   format_load = {24'h0, shifted[7:0]};
      F3_H:    format_load = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   format_load = {16'h0, shifted[15:0]};
      default: format_load = rdata;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= S_IDLE;
      addr_off_q            <= 2'b00;
      load_op_q             <= 3'b000;
      tmo_cnt               <= 32'd0;
      dmem.dmem_read        <= 1'b0;
      dmem.dmem_write       <= 1'b0;
      dmem.dmem_address     <= 32'd0;
      dmem.dmem_wdata       <= 32'd0;
      dmem.dmem_byte_enable <= 4'b0000;
      load_data             <= 32'd0;
      misaligned            <= 1'b0;
      bus_error             <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (access_req) begin
            addr_off_q <= addr[1:0];
            load_op_q  <= load_op;
            tmo_cnt    <= 32'd0;
            if (mis_req) begin
              // No memory traffic for a misaligned access.
              misaligned <= 1'b1;
              load_data  <= 32'd0;
              state      <= S_DONE;
            end else begin
              dmem.dmem_read        <= !mem_write;
              dmem.dmem_write       <= mem_write;
              dmem.dmem_address     <= {addr[31:2], 2'b00};
              dmem.dmem_wdata       <= mem_write ? st_wdata : 32'd0;
              dmem.dmem_byte_enable <= mem_write ? st_be : 4'b0000;
              state                 <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (dmem.dmem_resp) begin
            dmem.dmem_read  <= 1'b0;
            dmem.dmem_write <= 1'b0;
            load_data       <= dmem.dmem_read ?
                               format_load(load_op_q, addr_off_q, dmem.dmem_rdata) :
                               32'd0;
            state           <= S_DONE;
          end else if ((TIMEOUT_CYCLES != 0) && (tmo_cnt == TIMEOUT_CYCLES - 1)) begin
            // tmo_cnt counts completed ACCESS cycles without a response.
            dmem.dmem_read  <= 1'b0;
            dmem.dmem_write <= 1'b0;
            load_data       <= 32'd0;
            bus_error       <= 1'b1;
            state           <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        S_DONE: begin
          misaligned <= 1'b0;
          bus_error  <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
